prime_sieve_ctrl: RTL and testbench
===================================

# prime_sieve_ctrl

Controller that sequences a sieve of Eratosthenes over an external single-port bit memory and then serves "next prime after v" queries. On `start` it initialises the memory, strikes out composites, and raises `done`. From then on it answers queries through a valid/ready request/response pair. It replaces an all-combinational, single-cycle sieve with a multi-cycle engine that fits an FPGA block RAM. It sits between the game/display logic that consumes primes and a 1-bit-wide RAM.

## Interface
- `N_MAX`, default 1023: largest number represented; memory holds addresses 0..N_MAX.
- `AW`, default 10: address and value width; N_MAX < 2^AW.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse to (re)build the sieve.
- `busy`  out  1  high while the sieve is being built.
- `done`  out  1  high when the sieve is valid and queries are accepted.
- `mem_addr`  out  AW  memory address.
- `mem_we`  out  1  write enable.
- `mem_wdata`  out  1  write data (1 = prime).
- `mem_rdata`  in  1  read data, synchronous, valid the cycle after the address with `mem_we`=0.
- `query_valid`  in  1  query request.
- `query_ready`  out  1  query accepted when valid&&ready.
- `query_value`  in  AW  search starts after this value.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  response consumed when valid&&ready.
- `resp_prime`  out  AW  smallest prime > query_value, or 0 if none.
- `resp_none`  out  1  no prime in (query_value, N_MAX].

## Operation
- States: IDLE, INIT, OUT_RD, OUT_CHK, INNER, READY, Q_RD, Q_CHK, RESP.
- IDLE: `start` goes to INIT and sets `busy`=1, `done`=0.
- INIT: one write per cycle for addresses 0..N_MAX, with `mem_wdata` = (addr >= 2). Afterwards i=2 and the FSM goes to OUT_RD.
- OUT_RD: if i*i > N_MAX, go to READY. Otherwise read address i and go to OUT_CHK.
- OUT_CHK: if `mem_rdata`=1, set j=i*i and go to INNER. Otherwise set i=i+1 and go to OUT_RD.
- INNER: write 0 at j, then j=j+i, one write per cycle. When the next j > N_MAX, set i=i+1 and go to OUT_RD.
- Comparisons of i*i and j use 2*AW bits, so there is no wrap at the top of the range.
- READY: `busy`=0, `done`=1, `query_ready`=1.
- On query handshake: latch c=query_value+1 (AW+1 bits) and go to Q_RD. If query_value >= N_MAX, go straight to RESP with `resp_none`=1.
- Q_RD: if c > N_MAX, go to RESP with none. Otherwise read address c and go to Q_CHK.
- Q_CHK: if `mem_rdata`=1, go to RESP with `resp_prime`=c and `resp_none`=0. Otherwise set c=c+1 and go to Q_RD.
- RESP: `resp_valid`=1. `resp_prime` and `resp_none` stay stable until `resp_ready`, then the FSM returns to READY.
- `start` in READY rebuilds the sieve (to INIT, `done`=0).
- `start` in any other state is ignored.
- `query_valid` outside READY is not accepted.
- `mem_we`=0 in every state except INIT and INNER.
- `mem_addr` holds its last value when unused.

## Timing
- Reset: state IDLE. `busy`, `done`, `query_ready`, `resp_valid`, `resp_none`, `mem_we` and `mem_wdata` are 0; `mem_addr` and `resp_prime` are 0.
- Reset mid-operation: immediate return to IDLE. Memory contents are undefined and `done` stays 0 until a new `start`.
- `busy` rises the cycle after `start`. `done` rises the cycle after the final OUT_RD test fails.
- INIT takes N_MAX+1 cycles. Each outer candidate costs 2 cycles plus one cycle per multiple struck.
- Query accepted at edge T, result p: `resp_valid` rises 2*(p-v)+1 cycles after T. "None" takes 2*(N_MAX-v)+1 cycles; v >= N_MAX takes 1 cycle.
- `query_ready` is low from the accept edge until the response handshake completes. `query_ready` and `resp_valid` are never both high.

## Test plan
- Reset, then `start` with N_MAX=1023, then wait for `done`:
  - `busy` is high throughout, with zero writes outside 0..1023.
  - Dumped memory has exactly 172 ones, matching a golden sieve.
  - Bits 0 and 1 are 0.
- Queries v=1, 2, 24, 1020 -> `resp_prime` = 2, 3, 29, 1021, with `resp_none`=0 and latencies 3, 3, 11, 3.
- Query v=1021 -> `resp_none`=1, `resp_prime`=0 after 5 cycles. Query v=1023 -> `resp_none`=1 after 1 cycle.
- Hold `resp_ready` low for 5 cycles on the response to v=24:
  - `resp_valid` and `resp_prime`=29 stay stable.
  - `query_ready` stays 0.
  - A concurrent `query_valid` is not accepted.
- Assert `rst_n` low during INNER of i=3:
  - All outputs are zero at once.
  - A later `start` completes with the correct 172-prime memory.
- Pulse `start` while busy -> ignored, and the build completes normally. `start` in READY -> `done` drops and the sieve is rebuilt with identical results.

Source files
------------

// File: rtl/prime_sieve_ctrl.sv
// prime_sieve_ctrl: builds a sieve of Eratosthenes in an external 1-bit RAM,
// then answers "smallest prime greater than v" queries over valid/ready.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start, sieve not valid
// S_INIT    | writing 0..N_MAX, bit = (addr >= 2)
// S_OUT_RD  | outer loop: stop if i*i > N_MAX, else read bit i
// S_OUT_CHK | bit i available; prime -> strike multiples, else next i
// S_INNER   | writing 0 at j, j += i, one write per cycle
// S_READY   | sieve valid, query_ready high
// S_Q_RD    | query scan: stop if c > N_MAX, else read bit c
// S_Q_CHK   | bit c available; prime -> respond, else next c
// S_RESP    | response held until resp_ready
//
// The RAM samples its address on the rising edge and returns data the
// following cycle, so the address for each read is set up on the edge that
// enters the *_RD state. That keeps every candidate at two cycles.
// When c reaches N_MAX without a hit, Q_CHK answers "none" directly rather
// than spending another Q_RD cycle on an out-of-range address.
module prime_sieve_ctrl #(
  parameter int N_MAX = 1023,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_wdata,
  input  logic          mem_rdata,
  input  logic          query_valid,
  output logic          query_ready,
  input  logic [AW-1:0] query_value,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [AW-1:0] resp_prime,
  output logic          resp_none
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_OUT_RD, S_OUT_CHK, S_INNER,
    S_READY, S_Q_RD, S_Q_CHK, S_RESP
  } state_t;

  localparam logic [AW-1:0]   NMAX_A = AW'(N_MAX);
  localparam logic [AW:0]     NMAX_C = (AW+1)'(N_MAX);
  localparam logic [2*AW-1:0] NMAX_W = (2*AW)'(N_MAX);

  state_t            state;
  logic [AW-1:0]     i;
  logic [2*AW-1:0]   j;
  logic [AW:0]       c;

  logic [2*AW-1:0]   i_wide;
  logic [2*AW-1:0]   i_sq;
  logic [2*AW-1:0]   j_next;

  // Double-width arithmetic so i*i and j+i never wrap near the top of the range.
  always_comb begin
    i_wide = {{AW{1'b0}}, i};
    i_sq   = i_wide * i_wide;
    j_next = j + i_wide;
  end

  // Main sequencer; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= 1'b0;
      query_ready <= 1'b0;
      resp_valid  <= 1'b0;
      resp_prime  <= '0;
      resp_none   <= 1'b0;
      i           <= '0;
      j           <= '0;
      c           <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_INIT;
            busy      <= 1'b1;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b1;
            mem_wdata <= 1'b0;
          end
        end

        S_INIT: begin
          if (mem_addr == NMAX_A) begin
            mem_we    <= 1'b0;
            mem_wdata <= 1'b0;
            i         <= AW'(2);
            mem_addr  <= AW'(2);
            state     <= S_OUT_RD;
          end else begin
            mem_addr  <= mem_addr + AW'(1);
            // next address is >= 2 exactly when the current one is >= 1
            mem_wdata <= (mem_addr >= AW'(1));
          end
        end

        S_OUT_RD: begin
          if (i_sq > NMAX_W) begin
            state       <= S_READY;
            busy        <= 1'b0;
            done        <= 1'b1;
            query_ready <= 1'b1;
          end else begin
            state <= S_OUT_CHK;
          end
        end

        S_OUT_CHK: begin
          if (mem_rdata) begin
            j         <= i_sq;
            mem_addr  <= i_sq[AW-1:0];
            mem_we    <= 1'b1;
            mem_wdata <= 1'b0;
            state     <= S_INNER;
          end else begin
            i        <= i + AW'(1);
            mem_addr <= i + AW'(1);
            state    <= S_OUT_RD;
          end
        end

        S_INNER: begin
          if (j_next > NMAX_W) begin
            mem_we   <= 1'b0;
            i        <= i + AW'(1);
            mem_addr <= i + AW'(1);
            state    <= S_OUT_RD;
          end else begin
            j        <= j_next;
            mem_addr <= j_next[AW-1:0];
          end
        end

        S_READY: begin
          if (start) begin
            state       <= S_INIT;
            busy        <= 1'b1;
            done        <= 1'b0;
            query_ready <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b1;
            mem_wdata   <= 1'b0;
          end else if (query_valid) begin
            query_ready <= 1'b0;
            if (query_value >= NMAX_A) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_none  <= 1'b1;
              resp_prime <= '0;
            end else begin
              c        <= {1'b0, query_value} + (AW+1)'(1);
              mem_addr <= query_value + AW'(1);
              state    <= S_Q_RD;
            end
          end
        end

        S_Q_RD: begin
          if (c > NMAX_C) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_none  <= 1'b1;
            resp_prime <= '0;
          end else begin
            state <= S_Q_CHK;
          end
        end

        S_Q_CHK: begin
          if (mem_rdata) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_none  <= 1'b0;
            resp_prime <= c[AW-1:0];
          end else if (c >= NMAX_C) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_none  <= 1'b1;
            resp_prime <= '0;
          end else begin
            c        <= c + (AW+1)'(1);
            mem_addr <= c[AW-1:0] + AW'(1);
            state    <= S_Q_RD;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid  <= 1'b0;
            query_ready <= 1'b1;
            state       <= S_READY;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// Bench for prime_sieve_ctrl: behavioural 1-bit RAM, trial-division golden
// primes, scoreboard of expected query responses.
module tb_prime_sieve_ctrl;
  localparam int N_MAX = 1023;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_wdata;
  logic          mem_rdata;
  logic          query_valid = 1'b0;
  logic          query_ready;
  logic [AW-1:0] query_value = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [AW-1:0] resp_prime;
  logic          resp_none;

  prime_sieve_ctrl #(.N_MAX(N_MAX), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .query_valid(query_valid),
    .query_ready(query_ready), .query_value(query_value),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_prime(resp_prime), .resp_none(resp_none)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM; scramble models lost contents
  logic mem [0:N_MAX];
  logic scramble = 1'b0;
  always @(posedge clk) begin
    if (scramble) begin
      for (int k = 0; k <= N_MAX; k++) mem[k] <= 1'($urandom);
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int wr_idle  = 0;
  int overlap  = 0;

  bit golden [0:N_MAX];
  int golden_cycles;
  int golden_writes;

  typedef struct {
    int v;
    int prime;
    int none;
    int lat;
  } exp_t;
  exp_t sb[$];

  // activity monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) wr_count++;
      if (mem_we && !busy) wr_idle++;
      if (query_ready && resp_valid) overlap++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic build_golden();
    int strikes;
    for (int k = 0; k <= N_MAX; k++) golden[k] = is_prime(k);
    golden_cycles = (N_MAX + 1) + 1;
    golden_writes = N_MAX + 1;
    for (int p = 2; p * p <= N_MAX; p++) begin
      golden_cycles += 2;
      if (is_prime(p)) begin
        strikes = (N_MAX - p * p) / p + 1;
        golden_cycles += strikes;
        golden_writes += strikes;
      end
    end
  endtask

  // start from READY/IDLE, optionally pulse start again mid-build
  task automatic run_build(input int busy_pulse_cycle);
    int cyc;
    int busy_drops;
    start = 1'b1;
    wr_count = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_drops = 0;
    check("busy_rise", busy, 1);
    check("done_low_at_start", done, 0);
    while (!done && cyc < 20000) begin
      start = (cyc == busy_pulse_cycle);
      if (!busy) busy_drops++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("build_done", done, 1);
    check("build_cycles", cyc, golden_cycles + 1);
    check("busy_throughout", busy_drops, 0);
    check("busy_fall", busy, 0);
    check("query_ready_up", query_ready, 1);
    check("build_writes", wr_count, golden_writes);
  endtask

  task automatic check_mem();
    int ones;
    int mism;
    ones = 0;
    mism = 0;
    for (int k = 0; k <= N_MAX; k++) begin
      if (mem[k] === 1'b1) ones++;
      if (mem[k] !== golden[k]) mism++;
    end
    check("mem_ones", ones, 172);
    check("mem_vs_golden", mism, 0);
    check("mem_bit0", mem[0], 0);
    check("mem_bit1", mem[1], 0);
  endtask

  // issue a query; hold>0 stalls resp_ready while a second query is offered
  task automatic query(input int v, input int hold, input int side_v);
    exp_t e;
    int p;
    int lat;
    e.v = v;
    p = 0;
    for (int k = v + 1; k <= N_MAX; k++) if (golden[k]) begin p = k; break; end
    e.prime = p;
    e.none  = (p == 0);
    if (v >= N_MAX)      e.lat = 1;
    else if (p != 0)     e.lat = 2 * (p - v) + 1;
    else                 e.lat = 2 * (N_MAX - v) + 1;
    sb.push_back(e);

    check("qready_before", query_ready, 1);
    query_valid = 1'b1;
    query_value = AW'(v);
    lat = 0;
    do begin
      @(negedge clk);
      query_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 5000);

    e = sb.pop_front();
    check("resp_seen", resp_valid, 1);
    check("resp_latency", lat, e.lat);
    check("resp_prime", resp_prime, e.prime);
    check("resp_none", resp_none, e.none);
    check("qready_busy", query_ready, 0);

    if (hold > 0) begin
      query_valid = 1'b1;
      query_value = AW'(side_v);
      repeat (hold) begin
        @(negedge clk);
        check("stall_valid", resp_valid, 1);
        check("stall_prime", resp_prime, e.prime);
        check("stall_qready", query_ready, 0);
      end
      query_valid = 1'b0;
    end

    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_consumed", resp_valid, 0);
    check("qready_back", query_ready, 1);
    @(negedge clk);
    check("no_stray_resp", resp_valid, 0);
  endtask

  initial begin
    int k;
    build_golden();

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {busy, done, query_ready, resp_valid, resp_none, mem_we, mem_wdata, mem_addr, resp_prime}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // query offered in IDLE must be ignored
    query_valid = 1'b1;
    query_value = AW'(5);
    repeat (3) @(negedge clk);
    check("idle_qready", query_ready, 0);
    check("idle_no_resp", resp_valid, 0);
    query_valid = 1'b0;
    @(negedge clk);

    run_build(-1);
    check_mem();

    query(1, 0, 0);
    query(2, 0, 0);
    query(24, 5, 100);
    query(1020, 0, 0);
    query(1021, 0, 0);
    query(1023, 0, 0);

    // rebuild from READY with start pulses ignored during INIT and sieving
    run_build(500);
    check_mem();
    run_build(1500);
    check_mem();
    query(24, 0, 0);

    // reset during the first strike of i=3 (address 9)
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_we === 1'b1 && mem_addr == AW'(9) && mem_wdata === 1'b0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("inner_i3_reached", k < 5000, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs",
          {busy, done, query_ready, resp_valid, resp_none, mem_we, mem_wdata, mem_addr, resp_prime}, 0);
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    run_build(-1);
    check_mem();
    query(1020, 0, 0);

    check("writes_when_idle", wr_idle, 0);
    check("qready_resp_overlap", overlap, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
